wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 7 +
 rtl/wb_arbiter_rr_arbiter.sv | 26 ++
 rtl/wb_arbiter.sv | 102 ++++++++++
 tb/tb_wb_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared core constants for the writeback arbiter slice.
// Register file geometry and default datapath width.
package wb_arbiter_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin one-hot grant selector.
// Search starts one past the pointer and wraps.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);
  logic w_found;
  int   w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 1; i <= N; i++) begin
      w_idx = (int'(i_ptr) + i) % N;
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter with pending-register scoreboard.
// Define WB_ARBITER_FWD_EN to enable rf-write forwarding.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = XLEN_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [REG_AW*NUM_REQ-1:0] req_rd,
  input  logic [XLEN*NUM_REQ-1:0]   req_data,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [REG_AW-1:0]         rs1_addr,
  input  logic [REG_AW-1:0]         rs2_addr,
  output logic                      hazard_rs1,
  output logic                      hazard_rs2,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_rd_addr,
  output logic [XLEN-1:0]           rf_w_data,
  output logic                      fwd_rs1,
  output logic                      fwd_rs2
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]       r_last;
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic [NUM_REQ-1:0]  w_grant;
  logic [NUM_REQ-1:0]  w_gate;
  logic [PW-1:0]       w_gidx;
  logic [REG_AW-1:0]   w_rd;
  logic [XLEN-1:0]     w_data;
  logic                w_xfer;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_last),
    .o_grant (w_grant)
  );

  assign w_gate    = reset ? '0 : w_grant;
  assign req_ready = w_gate;
  assign w_xfer    = |(req_valid & w_gate);

  always_comb begin
    w_gidx = '0;
    w_rd   = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gate[i]) begin
        w_gidx = PW'(i);
        w_rd   = req_rd[REG_AW*i +: REG_AW];
        w_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  // Set after clear so a new producer overrides a retiring one.
  always_comb begin
    w_pend_nxt = r_pending;
    if (rf_we)
      w_pend_nxt[rf_rd_addr] = 1'b0;
    if (issue_valid && issue_rd != '0)
      w_pend_nxt[issue_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last     <= PW'(NUM_REQ - 1);
      r_pending  <= '0;
      rf_we      <= 1'b0;
      rf_rd_addr <= '0;
      rf_w_data  <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      rf_we     <= w_xfer && (w_rd != '0);
      if (w_xfer) begin
        r_last     <= w_gidx;
        rf_rd_addr <= w_rd;
        rf_w_data  <= w_data;
      end
    end
  end

`ifdef WB_ARBITER_FWD_EN
  assign fwd_rs1 = !reset && rf_we &&
                   (rf_rd_addr == rs1_addr) && (rs1_addr != '0);
  assign fwd_rs2 = !reset && rf_we &&
                   (rf_rd_addr == rs2_addr) && (rs2_addr != '0);
`else
  assign fwd_rs1 = 1'b0;
  assign fwd_rs2 = 1'b0;
`endif

  assign hazard_rs1 = !reset && r_pending[rs1_addr] && !fwd_rs1;
  assign hazard_rs2 = !reset && r_pending[rs2_addr] && !fwd_rs2;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
// Expectations follow WB_ARBITER_FWD_EN when defined.
module tb_wb_arbiter;
  localparam int N = 3;
  localparam int X = 32;
`ifdef WB_ARBITER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [5*N-1:0] req_rd;
  logic [X*N-1:0] req_data;
  logic           issue_valid;
  logic [4:0]     issue_rd;
  logic [4:0]     rs1_addr;
  logic [4:0]     rs2_addr;
  logic           hazard_rs1;
  logic           hazard_rs2;
  logic           rf_we;
  logic [4:0]     rf_rd_addr;
  logic [X-1:0]   rf_w_data;
  logic           fwd_rs1;
  logic           fwd_rs2;

  int n_chk = 0;
  int n_fail = 0;

  wb_arbiter #(.NUM_REQ(N), .XLEN(X)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .hazard_rs1  (hazard_rs1),
    .hazard_rs2  (hazard_rs2),
    .rf_we       (rf_we),
    .rf_rd_addr  (rf_rd_addr),
    .rf_w_data   (rf_w_data),
    .fwd_rs1     (fwd_rs1),
    .fwd_rs2     (fwd_rs2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 3'b111;
    req_rd      = {5'd3, 5'd2, 5'd1};
    req_data    = {32'hA2, 32'hA1, 32'hA0};
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
    step();
    step();
    check("rst_we", 32'(rf_we), 0);
    check("rst_addr", 32'(rf_rd_addr), 0);
    check("rst_data", rf_w_data, 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_haz", 32'(hazard_rs1), 0);
    check("rst_fwd", 32'(fwd_rs2), 0);

    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_grant", 32'(req_ready), 32'(1 << (c % 3)));
      step();
      check("rr_we", 32'(rf_we), 1);
      check("rr_addr", 32'(rf_rd_addr), 32'((c % 3) + 1));
      check("rr_data", rf_w_data, 32'(32'hA0 + (c % 3)));
    end
    req_valid = 3'b000;
    step();
    check("idle_we", 32'(rf_we), 0);
    step();
    req_valid = 3'b110;
    #1;
    check("hold_grant", 32'(req_ready), 32'b010);
    step();
    req_valid = 3'b000;

    // single transfer latency
    req_valid = 3'b001;
    req_rd    = {5'd3, 5'd2, 5'd5};
    req_data  = {32'hA2, 32'hA1, 32'hDEADBEEF};
    #1;
    check("lat_ready", 32'(req_ready), 32'b001);
    step();
    req_valid = 3'b000;
    check("lat_we1", 32'(rf_we), 1);
    check("lat_addr", 32'(rf_rd_addr), 5);
    check("lat_data", rf_w_data, 32'hDEADBEEF);
    step();
    check("lat_we2", 32'(rf_we), 0);

    // pending set then cleared by writeback
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    rs1_addr    = 5'd7;
    step();
    issue_valid = 1'b0;
    check("haz7_a", 32'(hazard_rs1), 1);
    step();
    check("haz7_b", 32'(hazard_rs1), 1);
    req_valid = 3'b010;
    req_rd    = {5'd3, 5'd7, 5'd5};
    #1;
    check("haz7_grant", 32'(req_ready), 32'b010);
    step();
    req_valid = 3'b000;
    check("haz7_we", 32'(rf_we), 1);
    check("haz7_c", 32'(hazard_rs1), 32'(!FWD));
    check("fwd7", 32'(fwd_rs1), 32'(FWD));
    step();
    check("haz7_d", 32'(hazard_rs1), 0);

    // set and clear of the same register collide
    rs1_addr  = 5'd9;
    req_valid = 3'b100;
    req_rd    = {5'd9, 5'd7, 5'd5};
    #1;
    check("r9_grant", 32'(req_ready), 32'b100);
    step();
    req_valid   = 3'b000;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    #1;
    check("r9_we", 32'(rf_we), 1);
    check("r9_addr", 32'(rf_rd_addr), 9);
    step();
    issue_valid = 1'b0;
    check("r9_haz_a", 32'(hazard_rs1), 1);
    step();
    check("r9_haz_b", 32'(hazard_rs1), 1);

    // rd=0 consumed without a write; x0 never pending
    req_valid = 3'b001;
    req_rd    = {5'd9, 5'd7, 5'd0};
    req_data  = {32'hA2, 32'hA1, 32'h1234};
    #1;
    check("x0_ready", 32'(req_ready), 32'b001);
    step();
    req_valid   = 3'b000;
    check("x0_we", 32'(rf_we), 0);
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    rs1_addr    = 5'd0;
    step();
    issue_valid = 1'b0;
    check("x0_haz", 32'(hazard_rs1), 0);

    // forwarding window on rs2
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    rs2_addr    = 5'd12;
    step();
    issue_valid = 1'b0;
    check("r12_haz_a", 32'(hazard_rs2), 1);
    req_valid = 3'b010;
    req_rd    = {5'd9, 5'd12, 5'd0};
    req_data  = {32'hA2, 32'hC0FFEE, 32'h0};
    #1;
    check("r12_grant", 32'(req_ready), 32'b010);
    step();
    req_valid = 3'b000;
    check("r12_we", 32'(rf_we), 1);
    check("r12_data", rf_w_data, 32'hC0FFEE);
    check("r12_fwd", 32'(fwd_rs2), 32'(FWD));
    check("r12_haz_b", 32'(hazard_rs2), 32'(!FWD));
    step();
    check("r12_haz_c", 32'(hazard_rs2), 0);

    // transfer offered during reset is dropped
    reset     = 1'b1;
    req_valid = 3'b001;
    req_rd    = {5'd9, 5'd12, 5'd3};
    #1;
    check("rr_rst_ready", 32'(req_ready), 0);
    check("rr_rst_haz", 32'(hazard_rs1), 0);
    step();
    check("rr_rst_we", 32'(rf_we), 0);
    rs1_addr = 5'd9;
    #1;
    check("rr_rst_pend", 32'(hazard_rs1), 0);
    reset     = 1'b0;
    req_valid = 3'b000;
    step();
    check("post_rst_pend", 32'(hazard_rs1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
